flash_sample_reader: RTL and testbench

- Consumer of the synchronized sample-rate pulse in the Simple iPod audio path.
- On each rising edge of sample_tick, already synchronized into clk, it emits one 8-bit audio sample.
- Samples come from 32-bit flash words fetched over an Avalon-MM read master; each word holds two 16-bit samples.
- Supports forward/backward playback, pause, restart, and address wrap-around.

---
 rtl/flash_reader_pkg.sv | 31 +++
 rtl/tick_edge_detect.sv | 22 ++
 rtl/flash_sample_reader.sv | 174 +++++++++++++++++
 tb/tb_flash_sample_reader.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_reader_pkg.sv
// Shared types and constants for the flash sample reader: FSM states,
// default flash geometry and the byte lanes that hold each 16-bit sample.
package flash_reader_pkg;

  localparam int          DEFAULT_ADDR_W    = 23;
  localparam logic [22:0] DEFAULT_LAST_ADDR = 23'h7FFFF;
  localparam int          DEFAULT_DATA_W    = 32;

  // MSB of the low and high 16-bit sample inside a 32-bit flash word.
  localparam int SAMPLE_LO_MSB = 15;
  localparam int SAMPLE_HI_MSB = 31;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_REQ        = 3'd1,
    ST_WAIT_DATA  = 3'd2,
    ST_OUT_FIRST  = 3'd3,
    ST_WAIT_TICK2 = 3'd4,
    ST_OUT_SECOND = 3'd5
  } state_t;

  // Audio output is the high byte of the selected 16-bit sample.
  function automatic logic [7:0] pick_sample(input logic [31:0] word,
                                             input logic        upper);
    if (upper) begin
      return word[SAMPLE_HI_MSB -: 8];
    end
    return word[SAMPLE_LO_MSB -: 8];
  endfunction

endpackage

// File: rtl/tick_edge_detect.sv
// Registered rising-edge detector for the already-synchronized sample tick;
// a level held high for many cycles yields a single rise.
module tick_edge_detect (
  input  logic clk,
  input  logic clr,
  input  logic in,
  output logic rise
);

  logic tick_d_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      tick_d_q <= 1'b0;
    end else begin
      tick_d_q <= in;
    end
  end

  assign rise = in & ~tick_d_q;

endmodule

// File: rtl/flash_sample_reader.sv
// Fetches 32-bit flash words over an Avalon-MM read master and emits one
// 8-bit audio sample per sample-tick rising edge, two samples per word.
module flash_sample_reader
  import flash_reader_pkg::*;
#(
  parameter int                ADDR_W    = DEFAULT_ADDR_W,
  parameter logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEFAULT_LAST_ADDR),
  parameter int                DATA_W    = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              sample_tick,
  input  logic              play,
  input  logic              dir_back,
  input  logic              restart,
  output logic              flash_read,
  output logic [ADDR_W-1:0] flash_addr,
  input  logic              flash_waitrequest,
  input  logic              flash_readdatavalid,
  input  logic [DATA_W-1:0] flash_readdata,
  output logic [7:0]        audio_out,
  output logic              audio_valid,
  output logic              overrun,
  output state_t            state_dbg
);

  // Avalon read handshake: flash_read and flash_addr are held stable from the
  // first REQ cycle until a clock edge that sees flash_waitrequest low; that
  // edge accepts the read and flash_read drops. Exactly one readdatavalid
  // beat is expected per accepted read.

  logic tick_rise;

  tick_edge_detect u_tick (
    .clk  (clk),
    .clr  (clr),
    .in   (sample_tick),
    .rise (tick_rise)
  );

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] word_q;
  logic              word_dir_q;
  logic              restart_pend_q;
  logic              restart_dir_q;
  logic              flash_read_q;
  logic [7:0]        audio_out_q;
  logic              audio_valid_q;
  logic              overrun_q;

  logic [ADDR_W-1:0] restart_target;
  logic [ADDR_W-1:0] pend_target;
  logic [ADDR_W-1:0] advance_addr;

  function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] a,
                                                  input logic              back);
    if (back) begin
      return (a == '0) ? LAST_ADDR : a - ADDR_W'(1);
    end
    return (a == LAST_ADDR) ? '0 : a + ADDR_W'(1);
  endfunction

  assign restart_target = dir_back      ? LAST_ADDR : '0;
  assign pend_target    = restart_dir_q ? LAST_ADDR : '0;
  assign advance_addr   = step_addr(addr_q, word_dir_q);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q        <= ST_IDLE;
      addr_q         <= '0;
      word_q         <= '0;
      word_dir_q     <= 1'b0;
      restart_pend_q <= 1'b0;
      restart_dir_q  <= 1'b0;
      flash_read_q   <= 1'b0;
      audio_out_q    <= '0;
      audio_valid_q  <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      audio_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (restart) begin
            addr_q    <= restart_target;
            overrun_q <= 1'b0;
          end else if (tick_rise && play) begin
            word_dir_q   <= dir_back;
            flash_read_q <= 1'b1;
            state_q      <= ST_REQ;
          end
        end

        ST_REQ: begin
          if (restart) begin
            restart_pend_q <= 1'b1;
            restart_dir_q  <= dir_back;
          end
          if (tick_rise) begin
            overrun_q <= 1'b1;
          end
          if (!flash_waitrequest) begin
            flash_read_q <= 1'b0;
            state_q      <= ST_WAIT_DATA;
          end
        end

        ST_WAIT_DATA: begin
          if (restart) begin
            restart_pend_q <= 1'b1;
            restart_dir_q  <= dir_back;
          end
          if (tick_rise) begin
            overrun_q <= 1'b1;
          end
          if (flash_readdatavalid) begin
            word_q  <= flash_readdata;
            state_q <= ST_OUT_FIRST;
          end
        end

        ST_OUT_FIRST: begin
          audio_out_q   <= pick_sample(word_q, word_dir_q);
          audio_valid_q <= 1'b1;
          // A restart raised during the fetch is honoured once the first
          // sample of the fetched word has gone out.
          if (restart_pend_q || restart) begin
            addr_q         <= restart_pend_q ? pend_target : restart_target;
            restart_pend_q <= 1'b0;
            overrun_q      <= 1'b0;
            state_q        <= ST_IDLE;
          end else begin
            state_q <= ST_WAIT_TICK2;
          end
        end

        ST_WAIT_TICK2: begin
          if (restart) begin
            addr_q    <= restart_target;
            overrun_q <= 1'b0;
            state_q   <= ST_IDLE;
          end else if (tick_rise && play) begin
            state_q <= ST_OUT_SECOND;
          end
        end

        ST_OUT_SECOND: begin
          audio_out_q   <= pick_sample(word_q, ~word_dir_q);
          audio_valid_q <= 1'b1;
          if (restart) begin
            addr_q    <= restart_target;
            overrun_q <= 1'b0;
          end else begin
            addr_q <= advance_addr;
          end
          state_q <= ST_IDLE;
        end

        default: begin
          flash_read_q <= 1'b0;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

  assign flash_read  = flash_read_q;
  assign flash_addr  = addr_q;
  assign audio_out   = audio_out_q;
  assign audio_valid = audio_valid_q;
  assign overrun     = overrun_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_flash_sample_reader.sv
// Directed bench for flash_sample_reader: a flash responder, a playback model
// that predicts samples and fetch addresses, and a per-cycle output checker.
module tb_flash_sample_reader;
  import flash_reader_pkg::*;

  localparam logic [22:0] LAST = 23'h7FFFF;

  logic        clk;
  logic        clr;
  logic        sample_tick;
  logic        play;
  logic        dir_back;
  logic        restart;
  logic        flash_read;
  logic [22:0] flash_addr;
  logic        flash_waitrequest;
  logic        flash_readdatavalid;
  logic [31:0] flash_readdata;
  logic [7:0]  audio_out;
  logic        audio_valid;
  logic        overrun;
  state_t      state_dbg;

  flash_sample_reader dut (
    .clk                 (clk),
    .clr                 (clr),
    .sample_tick         (sample_tick),
    .play                (play),
    .dir_back            (dir_back),
    .restart             (restart),
    .flash_read          (flash_read),
    .flash_addr          (flash_addr),
    .flash_waitrequest   (flash_waitrequest),
    .flash_readdatavalid (flash_readdatavalid),
    .flash_readdata      (flash_readdata),
    .audio_out           (audio_out),
    .audio_valid         (audio_valid),
    .overrun             (overrun),
    .state_dbg           (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  exp_q[$];
  logic [22:0] exp_addr_q[$];
  logic [7:0]  model_audio = 8'h00;
  int          av_count  = 0;
  int          av_expect = 0;

  // playback model
  logic [22:0] m_addr  = '0;
  logic [31:0] m_word  = '0;
  logic        m_dir   = 1'b0;
  int          m_phase = 0;

  // flash responder configuration
  int wr_cycles      = 0;
  int rd_lat         = 1;
  bit in_reset_test  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] flash_word(input logic [22:0] a);
    if (a == 23'd0)  return 32'hA1B2_C3D4;
    if (a == LAST)   return 32'h1122_3344;
    return {a[7:0] ^ 8'h3C, 8'h5A, a[7:0], 8'hA5};
  endfunction

  // Byte heard for a given half of a word: upper 16-bit sample or lower one.
  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic upper);
    return upper ? w[31:24] : w[15:8];
  endfunction

  // Playback rules: the first sample of a word is the low one going forward
  // and the high one going backward; after the second, step the address.
  task automatic model_tick();
    if (!play) return;
    if (m_phase == 0) begin
      exp_addr_q.push_back(m_addr);
      m_word = flash_word(m_addr);
      m_dir  = dir_back;
      exp_q.push_back(byte_of(m_word, m_dir));
      m_phase = 1;
    end else begin
      exp_q.push_back(byte_of(m_word, !m_dir));
      if (m_dir) m_addr = (m_addr == 23'd0) ? LAST : m_addr - 23'd1;
      else       m_addr = (m_addr == LAST) ? 23'd0 : m_addr + 23'd1;
      m_phase = 0;
    end
    av_expect++;
  endtask

  task automatic model_restart();
    m_addr  = dir_back ? LAST : 23'd0;
    m_phase = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue_tick(input int hold);
    @(negedge clk);
    sample_tick = 1'b1;
    repeat (hold) @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic pulse_restart();
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 80; i++) begin
      if (av_count >= av_expect) break;
      @(posedge clk);
      #2;
    end
    if (av_count < av_expect) check("valid_timeout", 32'(av_count), 32'(av_expect));
  endtask

  task automatic play_tick(input int hold);
    model_tick();
    issue_tick(hold);
    wait_valid();
  endtask

  // ---------------- flash responder ----------------
  initial begin : flash_slave
    logic [22:0] acc_addr;
    bit          aborted;
    flash_waitrequest   = 1'b0;
    flash_readdatavalid = 1'b0;
    flash_readdata      = '0;
    forever begin
      @(negedge clk);
      if (flash_read === 1'b1) begin
        aborted = 1'b0;
        flash_waitrequest = (wr_cycles > 0);
        for (int i = 0; i < wr_cycles; i++) begin
          @(negedge clk);
          if (in_reset_test) begin
            aborted = 1'b1;
            break;
          end
          check("read_held", 32'(flash_read), 32'd1);
        end
        flash_waitrequest = 1'b0;
        if (!aborted) begin
          acc_addr = flash_addr;
          if (exp_addr_q.size() == 0) check("read_expected", 32'(exp_addr_q.size()), 32'd1);
          else check("read_addr", 32'(flash_addr), 32'(exp_addr_q.pop_front()));
          @(negedge clk);
          check("read_drop", 32'(flash_read), 32'd0);
          repeat (rd_lat - 1) @(negedge clk);
          flash_readdata      = flash_word(acc_addr);
          flash_readdatavalid = 1'b1;
          @(negedge clk);
          flash_readdatavalid = 1'b0;
        end
      end
    end
  end

  // ---------------- per-cycle output checker ----------------
  initial begin : compare
    logic [7:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (audio_valid === 1'b1) begin
        av_count++;
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("audio_sample", 32'(audio_out), 32'(e));
          model_audio = e;
        end
      end else begin
        check("audio_hold", 32'(audio_out), 32'(model_audio));
      end
    end
  end

  // ---------------- directed scenarios ----------------
  initial begin
    clr = 1'b1;
    sample_tick = 1'b0;
    play = 1'b1;
    dir_back = 1'b0;
    restart = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_audio_out", 32'(audio_out), 32'h00);
    check("rst_audio_valid", 32'(audio_valid), 32'd0);
    check("rst_flash_read", 32'(flash_read), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_addr", 32'(flash_addr), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    clr = 1'b0;

    // forward play of word 0
    wr_cycles = 0; rd_lat = 2;
    model_tick();
    issue_tick(1);
    check("s1_read_high", 32'(flash_read), 32'd1);
    check("s1_read_addr", 32'(flash_addr), 32'd0);
    wait_valid();
    check("s1_first", 32'(audio_out), 32'hC3);
    play_tick(1);
    check("s1_second", 32'(audio_out), 32'hA1);
    check("s1_addr_adv", 32'(flash_addr), 32'd1);
    check("s1_valid_count", 32'(av_count), 32'd2);

    // backward from the end of the song, then both wrap directions
    dir_back = 1'b1;
    model_restart();
    pulse_restart();
    check("s2_restart_back", 32'(flash_addr), 32'h7FFFF);
    play_tick(1);
    check("s2_first_back", 32'(audio_out), 32'h11);
    play_tick(1);
    check("s2_second_back", 32'(audio_out), 32'h33);
    check("s2_addr_back", 32'(flash_addr), 32'h7FFFE);
    dir_back = 1'b0;
    model_restart();
    pulse_restart();
    dir_back = 1'b1;
    play_tick(1);
    play_tick(1);
    check("s2_wrap_to_last", 32'(flash_addr), 32'h7FFFF);
    dir_back = 1'b0;
    play_tick(1);
    check("s2_fwd_first_last", 32'(audio_out), 32'h33);
    play_tick(1);
    check("s2_wrap_to_zero", 32'(flash_addr), 32'd0);

    // stalled read with a tick during the stall
    wr_cycles = 5; rd_lat = 3;
    model_tick();
    issue_tick(1);
    issue_tick(1);
    wait_valid();
    check("s3_overrun_set", 32'(overrun), 32'd1);
    check("s3_state", 32'(state_dbg), 32'(ST_WAIT_TICK2));
    play_tick(1);
    check("s3_overrun_sticky", 32'(overrun), 32'd1);
    model_restart();
    pulse_restart();
    check("s3_overrun_clr", 32'(overrun), 32'd0);

    // pause between the two samples of a word
    wr_cycles = 0; rd_lat = 2;
    play_tick(1);
    play = 1'b0;
    repeat (3) issue_tick(1);
    repeat (3) @(negedge clk);
    check("s4_pause_addr", 32'(flash_addr), 32'd0);
    check("s4_pause_state", 32'(state_dbg), 32'(ST_WAIT_TICK2));
    play = 1'b1;
    play_tick(1);
    check("s4_resume", 32'(audio_out), 32'hA1);
    check("s4_resume_addr", 32'(flash_addr), 32'd1);

    // restart while waiting for data at address 5
    while (m_addr != 23'd5) begin
      play_tick(1);
      play_tick(1);
    end
    check("s5_at_addr5", 32'(flash_addr), 32'd5);
    rd_lat = 6;
    model_tick();
    issue_tick(1);
    pulse_restart();
    check("s5_still_waiting", 32'(state_dbg), 32'(ST_WAIT_DATA));
    model_restart();
    wait_valid();
    check("s5_first_emitted", 32'(audio_out), 32'h05);
    check("s5_restart_addr", 32'(flash_addr), 32'd0);
    check("s5_restart_state", 32'(state_dbg), 32'(ST_IDLE));
    rd_lat = 2;
    play_tick(1);
    check("s5_refetch_zero", 32'(audio_out), 32'hC3);
    play_tick(1);

    // long tick: one rise, one sample, no overrun
    rd_lat = 1;
    play_tick(4);
    check("s6_long_first", 32'(audio_out), 32'h01);
    play_tick(4);
    check("s6_long_second", 32'(audio_out), 32'h3D);
    repeat (4) @(negedge clk);
    check("s6_valid_count", 32'(av_count), 32'(av_expect));
    check("s6_no_overrun", 32'(overrun), 32'd0);

    // asynchronous reset during a stalled request
    wr_cycles = 20;
    in_reset_test = 1'b1;
    issue_tick(1);
    check("s7_in_req", 32'(flash_read), 32'd1);
    @(negedge clk);
    clr = 1'b1;
    model_audio = 8'h00;
    m_addr = '0;
    m_phase = 0;
    exp_addr_q.delete();
    #1;
    check("s7_read_async", 32'(flash_read), 32'd0);
    check("s7_audio_async", 32'(audio_out), 32'h00);
    check("s7_valid_async", 32'(audio_valid), 32'd0);
    check("s7_overrun_async", 32'(overrun), 32'd0);
    check("s7_addr_async", 32'(flash_addr), 32'd0);
    repeat (2) @(negedge clk);
    clr = 1'b0;
    in_reset_test = 1'b0;
    wr_cycles = 0; rd_lat = 2;
    play_tick(1);
    check("s7_after_reset", 32'(audio_out), 32'hC3);
    play_tick(1);
    check("s7_after_addr", 32'(flash_addr), 32'd1);

    repeat (5) @(negedge clk);
    check("end_exp_drained", 32'(exp_q.size()), 32'd0);
    check("end_addr_drained", 32'(exp_addr_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
